instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 27 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 76 +++++++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// FSM encoding, FIFO entry layout and an address alignment helper.
package instr_fetch_unit_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam int unsigned FIFO_DEPTH       = 2;

   // RUN fetches normally; DISCARD drops exactly one in-flight response.
   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_DISCARD = 1'b1
   } ifu_state_e;

   // One buffered instruction together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Force an address onto a 32-bit word boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Two-entry FIFO of {pc, instr} pairs between memory responses and decode.
// Flush empties it in one cycle and wins over push/pop; head reads as zero
// while empty so downstream never sees stale data.
module fetch_fifo
   import instr_fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [FIFO_DEPTH];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         push_ok_s, pop_ok_s;

   // Pointer and occupancy next-state; a full FIFO accepts a push only alongside a pop.
   always_comb begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         pop_ok_s  = pop_i & (count_q != 2'd0);
         push_ok_s = push_i & ((count_q != 2'd2) | pop_ok_s);
         if (push_ok_s) begin
            wr_ptr_d = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer, occupancy and storage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
      end
   end

   assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches with at most one request in
// flight, buffers responses in a 2-entry FIFO for decode, and handles
// redirects by flushing and, when needed, dropping one late response.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        id_ready_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            outstanding_q, outstanding_d;
   logic            rsp_s, pop_s, push_s, flush_s, issue_s, head_valid_s;
   logic [1:0]      fifo_count_s;
   logic [2:0]      occupancy_s;
   fetch_entry_t    push_entry_s, head_s;

   // A response only counts when a request is actually in flight.
   assign rsp_s        = imem_rvalid_i & outstanding_q;
   assign head_valid_s = (fifo_count_s != 2'd0);
   assign push_entry_s = '{pc: inflight_pc_q, instr: imem_rdata_i};

   // Next state, FIFO control and issue decision; redirect overrides everything else.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      outstanding_d = outstanding_q;
      flush_s       = 1'b0;
      push_s        = 1'b0;
      pop_s         = 1'b0;
      issue_s       = 1'b0;
      occupancy_s   = 3'd0;
      if (redirect_i) begin
         flush_s    = 1'b1;
         fetch_pc_d = align_word(redirect_pc_i);
         // Still waiting on an old response: it must be dropped when it lands.
         if (outstanding_q && !imem_rvalid_i) begin
            state_d       = ST_DISCARD;
            outstanding_d = 1'b1;
         end else begin
            state_d       = ST_RUN;
            outstanding_d = 1'b0;
         end
      end else begin
         pop_s = head_valid_s & id_ready_i;
         case (state_q)
            ST_RUN: begin
               push_s  = rsp_s;
               state_d = ST_RUN;
            end
            ST_DISCARD: begin
               push_s = 1'b0;
               if (rsp_s) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DISCARD;
               end
            end
            default: begin
               push_s  = 1'b0;
               state_d = ST_RUN;
            end
         endcase
         // Slots already claimed by buffered plus in-flight instructions after this pop.
         occupancy_s = {1'b0, fifo_count_s} + {2'b00, outstanding_q} - {2'b00, pop_s};
         issue_s     = rst_n & (~outstanding_q | rsp_s) & (occupancy_s < 3'd2);
         if (issue_s) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
            outstanding_d = 1'b1;
         end else if (rsp_s) begin
            outstanding_d = 1'b0;
         end else begin
            outstanding_d = outstanding_q;
         end
      end
   end

   // FSM, fetch PC and in-flight tracking registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= RESET_PC;
         outstanding_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         outstanding_q <= outstanding_d;
      end
   end

   fetch_fifo u_fetch_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (flush_s),
      .wdata_i (push_entry_s),
      .head_o  (head_s),
      .count_o (fifo_count_s)
   );

   assign imem_req_o  = issue_s;
   assign imem_addr_o = fetch_pc_q;
   assign if_valid_o  = head_valid_s;
   assign if_instr_o  = head_s.instr;
   assign if_pc_o     = head_s.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency memory model.
// Cycle 0 is the first cycle after rst_n rises; inputs change 2 time units
// after a rising edge and outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        id_ready_i = 1'b1;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;

   int total = 0;
   int bad   = 0;

   int          mem_lat   = 1;
   bit          stale_req = 1'b0;
   bit          mem_pend  = 1'b0;
   int          mem_cnt   = 0;
   logic [31:0] mem_addr  = 32'h0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_ready_i    (id_ready_i),
      .if_valid_o    (if_valid_o),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o)
   );

   always #5 clk = ~clk;

   // Instruction word the memory returns for an address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   // Memory: capture a request mid-cycle, answer mem_lat cycles later;
   // stale_req forces one unsolicited response.
   always begin
      @(negedge clk);
      if (imem_req_o === 1'b1) begin
         mem_pend = 1'b1;
         mem_addr = imem_addr_o;
         mem_cnt  = mem_lat;
      end
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      if (stale_req) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = 32'hDEAD_BEEF;
      end else if (mem_pend) begin
         if (mem_cnt <= 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_of(mem_addr);
            mem_pend      = 1'b0;
         end else begin
            mem_cnt = mem_cnt - 1;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   // Hold reset long enough for any old response to drain, then release; returns in cycle 0.
   task automatic do_reset(input int lat, input bit rdy);
      rst_n         = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      id_ready_i    = rdy;
      mem_lat       = lat;
      repeat (5) next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) next_cycle();
      @(negedge clk);
      total++;
      if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || if_instr_o !== 32'h0 || if_pc_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: got req=%b valid=%b instr=%h pc=%h, want 0 0 00000000 00000000",
                  imem_req_o, if_valid_o, if_instr_o, if_pc_o);
      end
   endtask

   // 1-cycle memory, decode always ready: one request and one instruction per cycle.
   task automatic test_stream();
      logic exp_req, exp_valid, chk;
      logic [31:0] exp_addr, exp_pc;
      do_reset(1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp_req = 1'b1; exp_addr = 32'(c * 4); chk = 1'b1;
         exp_valid = (c >= 2); exp_pc = 32'((c - 2) * 4);
         if (chk) begin
            total++;
            if (imem_req_o !== exp_req || imem_addr_o !== exp_addr || if_valid_o !== exp_valid ||
                (exp_valid && (if_pc_o !== exp_pc || if_instr_o !== instr_of(exp_pc)))) begin
               bad++;
               $display("FAIL stream c%0d: got req=%b addr=%h valid=%b pc=%h instr=%h, want req=%b addr=%h valid=%b pc=%h",
                        c, imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, exp_req, exp_addr, exp_valid, exp_pc);
            end
         end
         next_cycle();
      end
   endtask

   // Decode stalls cycles 0..7: FIFO fills, requests stop, head holds; order kept after release.
   task automatic test_stall();
      logic exp_req, chk_req, exp_valid;
      logic [31:0] exp_addr, exp_pc;
      do_reset(1, 1'b0);
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         chk_req = 1'b1; exp_req = 1'b0; exp_addr = 32'h0;
         exp_valid = 1'b1; exp_pc = 32'h0;
         case (c)
            0:       begin exp_req = 1'b1; exp_addr = 32'h0; exp_valid = 1'b0; end
            1:       begin exp_req = 1'b1; exp_addr = 32'h4; exp_valid = 1'b0; end
            8:       begin exp_req = 1'b1; exp_addr = 32'h8; end
            9:       begin exp_req = 1'b1; exp_addr = 32'hC; exp_pc = 32'h4; end
            10:      begin chk_req = 1'b0; exp_pc = 32'h8; end
            default: begin exp_req = 1'b0; end
         endcase
         if (chk_req) begin
            total++;
            if (imem_req_o !== exp_req || (exp_req && imem_addr_o !== exp_addr)) begin
               bad++;
               $display("FAIL stall_req c%0d: got req=%b addr=%h, want req=%b addr=%h",
                        c, imem_req_o, imem_addr_o, exp_req, exp_addr);
            end
         end
         total++;
         if (if_valid_o !== exp_valid || (exp_valid && (if_pc_o !== exp_pc || if_instr_o !== instr_of(exp_pc)))) begin
            bad++;
            $display("FAIL stall_head c%0d: got valid=%b pc=%h instr=%h, want valid=%b pc=%h",
                     c, if_valid_o, if_pc_o, if_instr_o, exp_valid, exp_pc);
         end
         next_cycle();
         id_ready_i = (c + 1 >= 8);
      end
   endtask

   // 3-cycle memory: redirect to 0x100 while 0x8 is in flight; its response is dropped.
   task automatic test_redirect_outstanding();
      logic exp_req, exp_valid;
      logic [31:0] exp_addr, exp_pc;
      do_reset(3, 1'b1);
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         exp_req = 1'b0; exp_addr = 32'h0; exp_valid = 1'b0; exp_pc = 32'h0;
         case (c)
            0:       begin exp_req = 1'b1; exp_addr = 32'h0; end
            3:       begin exp_req = 1'b1; exp_addr = 32'h4; end
            4:       begin exp_valid = 1'b1; exp_pc = 32'h0; end
            6:       begin exp_req = 1'b1; exp_addr = 32'h8; end
            7:       begin exp_valid = 1'b1; exp_pc = 32'h4; end
            9:       begin exp_req = 1'b1; exp_addr = 32'h100; end
            12:      begin exp_req = 1'b1; exp_addr = 32'h104; end
            13:      begin exp_valid = 1'b1; exp_pc = 32'h100; end
            default: begin exp_req = 1'b0; end
         endcase
         total++;
         if (imem_req_o !== exp_req || (exp_req && imem_addr_o !== exp_addr) || if_valid_o !== exp_valid ||
             (exp_valid && (if_pc_o !== exp_pc || if_instr_o !== instr_of(exp_pc)))) begin
            bad++;
            $display("FAIL redir_outst c%0d: got req=%b addr=%h valid=%b pc=%h instr=%h, want req=%b addr=%h valid=%b pc=%h",
                     c, imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, exp_req, exp_addr, exp_valid, exp_pc);
         end
         next_cycle();
         redirect_i    = (c + 1 == 8);
         redirect_pc_i = 32'h100;
      end
      redirect_i = 1'b0;
   endtask

   // 1-cycle memory: redirect in cycle 2 together with rvalid; no DISCARD, fetch resumes at once.
   task automatic test_redirect_on_rvalid(input logic [31:0] target, input logic [31:0] first_pc,
                                          input logic [31:0] second_pc);
      logic exp_req, exp_valid, chk;
      logic [31:0] exp_addr, exp_pc;
      do_reset(1, 1'b1);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk = 1'b1; exp_req = 1'b0; exp_addr = 32'h0; exp_valid = 1'b0; exp_pc = 32'h0;
         case (c)
            2:       begin exp_req = 1'b0; exp_valid = 1'b1; exp_pc = 32'h0; end
            3:       begin exp_req = 1'b1; exp_addr = first_pc; end
            4:       begin exp_req = 1'b1; exp_addr = second_pc; end
            5:       begin exp_req = 1'b1; exp_addr = second_pc + 32'd4; exp_valid = 1'b1; exp_pc = first_pc; end
            6:       begin exp_req = 1'b1; exp_addr = second_pc + 32'd8; exp_valid = 1'b1; exp_pc = second_pc; end
            default: begin chk = 1'b0; end
         endcase
         if (chk) begin
            total++;
            if (imem_req_o !== exp_req || (exp_req && imem_addr_o !== exp_addr) || if_valid_o !== exp_valid ||
                (exp_valid && (if_pc_o !== exp_pc || if_instr_o !== instr_of(exp_pc)))) begin
               bad++;
               $display("FAIL redir_rvalid t=%h c%0d: got req=%b addr=%h valid=%b pc=%h instr=%h, want req=%b addr=%h valid=%b pc=%h",
                        target, c, imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, exp_req, exp_addr, exp_valid, exp_pc);
            end
         end
         next_cycle();
         redirect_i    = (c + 1 == 2);
         redirect_pc_i = target;
      end
      redirect_i = 1'b0;
   endtask

   // 3-cycle memory: redirect in cycle 4 enters DISCARD, second redirect in cycle 5 retargets.
   task automatic test_redirect_in_discard();
      logic exp_req, exp_valid;
      logic [31:0] exp_addr, exp_pc;
      do_reset(3, 1'b1);
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         exp_req = 1'b0; exp_addr = 32'h0; exp_valid = 1'b0; exp_pc = 32'h0;
         case (c)
            0:       begin exp_req = 1'b1; exp_addr = 32'h0; end
            3:       begin exp_req = 1'b1; exp_addr = 32'h4; end
            4:       begin exp_valid = 1'b1; exp_pc = 32'h0; end
            6:       begin exp_req = 1'b1; exp_addr = 32'h300; end
            9:       begin exp_req = 1'b1; exp_addr = 32'h304; end
            10:      begin exp_valid = 1'b1; exp_pc = 32'h300; end
            default: begin exp_req = 1'b0; end
         endcase
         total++;
         if (imem_req_o !== exp_req || (exp_req && imem_addr_o !== exp_addr) || if_valid_o !== exp_valid ||
             (exp_valid && (if_pc_o !== exp_pc || if_instr_o !== instr_of(exp_pc)))) begin
            bad++;
            $display("FAIL redir_discard c%0d: got req=%b addr=%h valid=%b pc=%h instr=%h, want req=%b addr=%h valid=%b pc=%h",
                     c, imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, exp_req, exp_addr, exp_valid, exp_pc);
         end
         next_cycle();
         redirect_i    = (c + 1 == 4) || (c + 1 == 5);
         redirect_pc_i = (c + 1 == 4) ? 32'h100 : 32'h300;
      end
      redirect_i = 1'b0;
   endtask

   // Reset pulsed in cycles 5-6 with 0x4 in flight; a stale rvalid in the first cycle after release is ignored.
   task automatic test_reset_midop();
      logic exp_req, exp_valid, chk;
      logic [31:0] exp_addr, exp_pc;
      do_reset(3, 1'b1);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk = 1'b1; exp_req = 1'b0; exp_addr = 32'h0; exp_valid = 1'b0; exp_pc = 32'h0;
         case (c)
            0:       begin exp_req = 1'b1; exp_addr = 32'h0; end
            3:       begin exp_req = 1'b1; exp_addr = 32'h4; end
            4:       begin exp_valid = 1'b1; exp_pc = 32'h0; end
            5, 6:    begin exp_req = 1'b0; end
            7:       begin exp_req = 1'b1; exp_addr = 32'h0; end
            8, 9:    begin exp_req = 1'b0; end
            10:      begin exp_req = 1'b1; exp_addr = 32'h4; end
            11:      begin exp_req = 1'b0; exp_valid = 1'b1; exp_pc = 32'h0; end
            default: begin chk = 1'b0; end
         endcase
         if (chk) begin
            total++;
            if (imem_req_o !== exp_req || (exp_req && imem_addr_o !== exp_addr) || if_valid_o !== exp_valid ||
                (!exp_valid && (if_pc_o !== 32'h0 || if_instr_o !== 32'h0)) ||
                (exp_valid && (if_pc_o !== exp_pc || if_instr_o !== instr_of(exp_pc)))) begin
               bad++;
               $display("FAIL reset_midop c%0d: got req=%b addr=%h valid=%b pc=%h instr=%h, want req=%b addr=%h valid=%b pc=%h",
                        c, imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, exp_req, exp_addr, exp_valid, exp_pc);
            end
         end
         stale_req = (c == 6);
         next_cycle();
         stale_req = 1'b0;
         rst_n     = !((c + 1 == 5) || (c + 1 == 6));
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_outstanding();
      test_redirect_on_rvalid(32'h0000_0203, 32'h0000_0200, 32'h0000_0204);
      test_redirect_on_rvalid(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
      test_redirect_in_discard();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
